mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/memarb_watchdog.sv | 26 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: bus word, arbiter FSM
// states and the requester identity used for grants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } memarb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } memarb_req_t;

endpackage

// File: rtl/memarb_watchdog.sv
// Access watchdog: counts RAM access cycles that did not complete and
// flags when the count sits at the abort limit (TIMEOUT_CYCLES-1).
module memarb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // Count stalled access cycles; clear takes priority over counting.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 8'd1;
  end

  assign done = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache with an access
// watchdog. Optional build macro MEMARB_ROUND_ROBIN_EN: ties alternate
// between requesters; without it a tie always goes to the dcache.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  // icache
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  iwait,
  // dcache
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dwait,
  // RAM
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramrdy,
  // status
  output logic  err_timeout
);

  memarb_state_t state;
  memarb_req_t   grant;
  memarb_req_t   tieGrant;
  memarb_req_t   pick;
  logic          dReq, anyReq, iAcc, dAcc, inAcc, reqLive, wdDone;

  assign dReq   = dREN | dWEN;
  assign anyReq = iREN | dReq;
  assign iAcc   = (state == IACC);
  assign dAcc   = (state == DACC);
  assign inAcc  = iAcc | dAcc;
  // The granted requester still wants the bus; dropping it aborts the access.
  assign reqLive = inAcc & ((grant == REQ_I) ? iREN : dReq);

`ifdef MEMARB_ROUND_ROBIN_EN
  memarb_req_t lastGrant;
  assign tieGrant = (lastGrant == REQ_I) ? REQ_D : REQ_I;
`else
  assign tieGrant = REQ_D;
`endif

  // Select the requester to grant from IDLE.
  always_comb begin
    pick = REQ_D;
    if (iREN && dReq) pick = tieGrant;
    else if (iREN)    pick = REQ_I;
  end

  // Arbiter FSM: grant from IDLE, return to IDLE on completion, abort or timeout.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      grant       <= REQ_I;
      err_timeout <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
      lastGrant   <= REQ_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            state <= (pick == REQ_I) ? IACC : DACC;
            grant <= pick;
`ifdef MEMARB_ROUND_ROBIN_EN
            lastGrant <= pick;
`endif
          end
        end
        default: begin
          if (!reqLive || ramrdy) begin
            state <= IDLE;
          end else if (wdDone) begin
            // Requester keeps waiting and will be re-granted after the bubble.
            state       <= IDLE;
            err_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  // Every access is preceded by an IDLE cycle, so clearing in IDLE
  // gives a zero count on the first access cycle.
  memarb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (state == IDLE),
    .enable(inAcc & ~ramrdy),
    .done  (wdDone)
  );

  // RAM strobes follow the live request so an abort drops them at once.
  assign ramREN   = (iAcc & iREN) | (dAcc & dREN & ~dWEN);
  assign ramWEN   = dAcc & dWEN;
  assign ramaddr  = iAcc ? iaddr : (dAcc ? daddr : '0);
  assign ramstore = dAcc ? dstore : '0;

  assign iwait = ~(iAcc & ramrdy);
  assign dwait = ~(dAcc & ramrdy);
  assign iload = iAcc ? ramload : '0;
  assign dload = dAcc ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard queues hold expected
// load data / write records and expected grant order.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 16;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  iREN, dREN, dWEN, ramrdy;
  word_t iaddr, daddr, dstore, ramload;
  word_t iload, dload, ramaddr, ramstore;
  logic  iwait, dwait, ramREN, ramWEN, err_timeout;

  int checks   = 0;
  int failures = 0;

  word_t       expQ[$];
  memarb_req_t grantQ[$];

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramrdy(ramrdy),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramrdy = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic test_reset();
    nRST = 0; iREN = 1; dREN = 1; dWEN = 1; ramrdy = 1;
    iaddr = 32'h55; daddr = 32'h66; dstore = 32'h77; ramload = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00", {ramREN, ramWEN});
    end
    checks++;
    if ({ramaddr, ramstore} !== 64'h0) begin
      failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", ramaddr, ramstore);
    end
    checks++;
    if ({iwait, dwait} !== 2'b11) begin
      failures++; $display("FAIL reset_waits got=%b exp=11", {iwait, dwait});
    end
    checks++;
    if ({iload, dload} !== 64'h0) begin
      failures++; $display("FAIL reset_loads got=%h/%h exp=0/0", iload, dload);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", err_timeout);
    end
    idle_inputs();
    @(posedge CLK); #1 nRST = 1;
  endtask

  task automatic test_iread();
    iREN = 1; iaddr = 32'h100; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0) begin
      failures++; $display("FAIL iread_idle_ren got=%b exp=0", ramREN);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h100, 1'b1}) begin
      failures++; $display("FAIL iread_acc1 got ren=%b addr=%h iwait=%b exp 1/100/1",
                           ramREN, ramaddr, iwait);
    end
    @(posedge CLK); #1 ramrdy = 1; expQ.push_back(32'hDEADBEEF);
    @(negedge CLK);
    checks++;
    if (iwait !== 1'b0 || dwait !== 1'b1) begin
      failures++; $display("FAIL iread_done got iwait=%b dwait=%b exp 0/1", iwait, dwait);
    end else begin
      word_t e = expQ.pop_front();
      checks++;
      if (iload !== e) begin
        failures++; $display("FAIL iread_data got=%h exp=%h", iload, e);
      end
    end
    @(posedge CLK); #1 iREN = 0; ramrdy = 0;
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait, ramaddr} !== {1'b0, 1'b1, 32'h0}) begin
      failures++; $display("FAIL iread_bubble got ren=%b iwait=%b addr=%h exp 0/1/0",
                           ramREN, iwait, ramaddr);
    end
    idle_inputs();
  endtask

  task automatic test_dwrite();
    word_t ea, ed;
    dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
    expQ.push_back(32'h200); expQ.push_back(32'h12345678);
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if ({ramWEN, ramREN, dwait, ramaddr, ramstore} !==
          {1'b1, 1'b0, 1'b1, 32'h200, 32'h12345678}) begin
        failures++; $display("FAIL dwrite_hold%0d got wen=%b ren=%b dwait=%b addr=%h st=%h",
                             k, ramWEN, ramREN, dwait, ramaddr, ramstore);
      end
      @(posedge CLK); #1;
    end
    ramrdy = 1;
    @(negedge CLK);
    ea = expQ.pop_front(); ed = expQ.pop_front();
    checks++;
    if ({dwait, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b1, ea, ed}) begin
      failures++; $display("FAIL dwrite_done got dwait=%b wen=%b addr=%h st=%h exp 0/1/%h/%h",
                           dwait, ramWEN, ramaddr, ramstore, ea, ed);
    end
    @(posedge CLK); #1 dWEN = 0; ramrdy = 0;
    @(negedge CLK);
    checks++;
    if ({dwait, ramWEN} !== 2'b10) begin
      failures++; $display("FAIL dwrite_one_pulse got dwait=%b wen=%b exp 1/0", dwait, ramWEN);
    end
    idle_inputs();
  endtask

  task automatic test_dread_and_rw();
    // Read completing on the first access cycle.
    dREN = 1; daddr = 32'h300; ramload = 32'hCAFEF00D; ramrdy = 1;
    expQ.push_back(32'hCAFEF00D);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (dwait !== 1'b0 || ramREN !== 1'b1) begin
      failures++; $display("FAIL dread_done got dwait=%b ren=%b exp 0/1", dwait, ramREN);
    end else begin
      word_t e = expQ.pop_front();
      checks++;
      if (dload !== e || iload !== 32'h0) begin
        failures++; $display("FAIL dread_data got d=%h i=%h exp %h/0", dload, iload, e);
      end
    end
    @(posedge CLK); #1 dREN = 0; ramrdy = 0;
    // dREN and dWEN together behave as a write.
    dREN = 1; dWEN = 1; daddr = 32'h340; dstore = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, ramstore} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
      failures++; $display("FAIL rw_is_write got wen=%b ren=%b st=%h exp 1/0/a5a5a5a5",
                           ramWEN, ramREN, ramstore);
    end
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_tie();
    nRST = 0; #1 nRST = 1;
`ifdef MEMARB_ROUND_ROBIN_EN
    grantQ.push_back(REQ_D); grantQ.push_back(REQ_I); grantQ.push_back(REQ_D);
`else
    grantQ.push_back(REQ_D); grantQ.push_back(REQ_D); grantQ.push_back(REQ_D);
`endif
    @(posedge CLK); #1;
    iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h500; ramrdy = 1;
    for (int cyc = 0; cyc < 20 && grantQ.size() != 0; cyc++) begin
      @(negedge CLK);
      if (!iwait || !dwait) begin
        memarb_req_t got = iwait ? REQ_D : REQ_I;
        memarb_req_t exp = grantQ.pop_front();
        checks++;
        if (got !== exp || (!iwait && !dwait)) begin
          failures++; $display("FAIL tie_order got=%s exp=%s iwait=%b dwait=%b",
                               got.name(), exp.name(), iwait, dwait);
        end
      end
    end
    checks++;
    if (grantQ.size() != 0) begin
      failures++; $display("FAIL tie_timeout got=%0d pending exp=0", grantQ.size());
      grantQ.delete();
    end
    @(posedge CLK); #1 idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic test_abort();
    dREN = 1; daddr = 32'h600;
    @(posedge CLK); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b1) begin
        failures++; $display("FAIL abort_pre%0d got ren=%b exp=1", k, ramREN);
      end
      @(posedge CLK); #1;
    end
    dREN = 0; #1;
    checks++;
    if ({ramREN, dwait} !== 2'b01) begin
      failures++; $display("FAIL abort_drop got ren=%b dwait=%b exp 0/1", ramREN, dwait);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({ramaddr, err_timeout} !== {32'h0, 1'b0}) begin
      failures++; $display("FAIL abort_idle got addr=%h err=%b exp 0/0", ramaddr, err_timeout);
    end
    idle_inputs();
  endtask

  task automatic test_limit_ready();
    dREN = 1; daddr = 32'h680; ramload = 32'h0BADF00D;
    @(posedge CLK); #1;
    for (int k = 1; k < TO; k++) begin
      @(negedge CLK);
      checks++;
      if (dwait !== 1'b1 || ramREN !== 1'b1) begin
        failures++; $display("FAIL limit_stall%0d got dwait=%b ren=%b exp 1/1", k, dwait, ramREN);
      end
      @(posedge CLK); #1;
    end
    ramrdy = 1; expQ.push_back(32'h0BADF00D);
    @(negedge CLK);
    checks++;
    if (dwait !== 1'b0) begin
      failures++; $display("FAIL limit_done got dwait=%b exp=0", dwait);
      void'(expQ.pop_front());
    end else begin
      word_t e = expQ.pop_front();
      checks++;
      if (dload !== e) begin
        failures++; $display("FAIL limit_data got=%h exp=%h", dload, e);
      end
    end
    @(posedge CLK); #1 idle_inputs();
    @(negedge CLK);
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL limit_err got=%b exp=0", err_timeout);
    end
  endtask

  task automatic test_timeout();
    dREN = 1; daddr = 32'h700;
    @(posedge CLK); #1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge CLK);
      checks++;
      if ({dwait, ramREN, err_timeout} !== 3'b110) begin
        failures++; $display("FAIL timeout_acc%0d got dwait=%b ren=%b err=%b exp 1/1/0",
                             k, dwait, ramREN, err_timeout);
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++;
    if ({err_timeout, ramREN, dwait, ramaddr} !== {3'b101, 32'h0}) begin
      failures++; $display("FAIL timeout_abort got err=%b ren=%b dwait=%b addr=%h exp 1/0/1/0",
                           err_timeout, ramREN, dwait, ramaddr);
    end
    @(posedge CLK); #1 dREN = 0;
    // A later successful access leaves the flag set.
    iREN = 1; ramrdy = 1;
    repeat (3) @(posedge CLK);
    #1 idle_inputs();
    @(negedge CLK);
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    iREN = 1; iaddr = 32'h800; ramload = 32'h11112222;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h800}) begin
      failures++; $display("FAIL rstmid_acc got ren=%b addr=%h exp 1/800", ramREN, ramaddr);
    end
    #1 nRST = 0; #1;
    checks++;
    if ({ramREN, ramWEN, ramaddr, iwait, dwait, iload, err_timeout} !==
        {2'b00, 32'h0, 2'b11, 32'h0, 1'b0}) begin
      failures++; $display("FAIL rstmid_async got ren=%b addr=%h iwait=%b iload=%h err=%b",
                           ramREN, ramaddr, iwait, iload, err_timeout);
    end
    ramrdy = 1;
    @(posedge CLK); #1;
    checks++;
    if (iwait !== 1'b1 || ramREN !== 1'b0) begin
      failures++; $display("FAIL rstmid_nopulse got iwait=%b ren=%b exp 1/0", iwait, ramREN);
    end
    idle_inputs();
    @(posedge CLK); #1 nRST = 1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_iread();
    test_dwrite();
    test_dread_and_rw();
    test_tie();
    test_abort();
    test_limit_ready();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
